game_ctrl: RTL

Round controller that drives the countdown timer's control inputs: start (run level) and miss (penalty request). It consumes the timer's remaining count and fail flag. It presents a one-hot target to the player and scores button presses against it. It ends the game on win (score target reached) or on timer fail.

---
 rtl/game_pkg.sv | 21 ++
 rtl/btn_sync_edge.sv | 30 +++
 rtl/game_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round controller and its timer.
// Pure definitions; no latency or backpressure of its own.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WIN  = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int TICK_PERIOD_DEF = 5001;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// 2-FF synchronizer plus rising-edge detector for asynchronous push buttons.
// Pulse appears 2 clocks after the raw edge is first sampled; no backpressure.
module btn_sync_edge #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] pulse
);

  logic [W-1:0] sync_a;
  logic [W-1:0] sync_b;
  logic [W-1:0] sync_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_a    <= '0;
      sync_b    <= '0;
      sync_prev <= '0;
    end else begin
      sync_a    <= raw;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
    end
  end

  assign pulse = sync_b & ~sync_prev;

endmodule

// File: rtl/game_ctrl.sv
// Round controller: drives timer start/miss, lights a one-hot target and scores presses.
// Press acts 3 clocks after the raw edge; presses during lockout or penalty are dropped.
module game_ctrl
  import game_pkg::*;
#(
  parameter int         N_BTN       = 4,
  parameter int         TICK_PERIOD = TICK_PERIOD_DEF,
  parameter int         MISS_HOLD   = 5001,
  parameter int         LOCKOUT     = 250000,
  parameter int         WIN_SCORE   = 20,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_start,
  input  logic [N_BTN-1:0] btn_hit,
  input  logic             game_fail_in,
  input  logic [22:0]      timer_in,
  output logic             start,
  output logic             miss,
  output logic [N_BTN-1:0] target,
  output logic [7:0]       score,
  output logic             game_win,
  output logic [1:0]       state
);

  localparam int IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  // The timer only samples miss once per tick, so never hold it for less than a tick
  localparam int HOLD   = (MISS_HOLD > TICK_PERIOD) ? MISS_HOLD : TICK_PERIOD;
  localparam int MISS_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int LOCK_W = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

  state_t             st, st_nxt;
  logic               start_pulse;
  logic [N_BTN-1:0]   hit_pulse;
  logic [7:0]         lfsr;
  logic [IDX_W-1:0]   idx, idx_new, lfsr_idx;
  logic [MISS_W-1:0]  miss_cnt;
  logic [LOCK_W-1:0]  lock_cnt;
  logic [7:0]         score_r;
  logic [N_BTN-1:0]   tgt_oh;
  logic               armed, eval, hit_ok, hit_wrong;
  logic               unused_timer;

  assign unused_timer = ^timer_in;

  btn_sync_edge #(.W(1)) u_sync_start (
    .clock (clock),
    .reset (reset),
    .raw   (btn_start),
    .pulse (start_pulse)
  );

  btn_sync_edge #(.W(N_BTN)) u_sync_hit (
    .clock (clock),
    .reset (reset),
    .raw   (btn_hit),
    .pulse (hit_pulse)
  );

  assign tgt_oh    = N_BTN'(1) << idx;
  assign armed     = (lock_cnt == '0) && (miss_cnt == '0);
  // A same-cycle timer failure wins over any press
  assign eval      = (st == ST_RUN) && armed && (|hit_pulse) && !game_fail_in;
  assign hit_ok    = eval && (hit_pulse == tgt_oh);
  assign hit_wrong = eval && (hit_pulse != tgt_oh);

  assign lfsr_idx  = lfsr[IDX_W-1:0];
  assign idx_new   = (lfsr_idx == idx) ? idx + IDX_W'(1) : lfsr_idx;

  always_comb begin
    st_nxt   = st;
    start    = 1'b0;
    miss     = 1'b0;
    target   = '0;
    game_win = 1'b0;
    case (st)
      ST_IDLE: begin
        target = tgt_oh;
        if (start_pulse) st_nxt = ST_RUN;
      end
      ST_RUN: begin
        start  = 1'b1;
        miss   = (miss_cnt != '0);
        target = tgt_oh;
        if (game_fail_in)                 st_nxt = ST_FAIL;
        else if (score_r == 8'(WIN_SCORE)) st_nxt = ST_WIN;
      end
      ST_WIN:  game_win = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st       <= ST_IDLE;
      lfsr     <= LFSR_SEED;
      idx      <= '0;
      miss_cnt <= '0;
      lock_cnt <= '0;
      score_r  <= '0;
    end else begin
      st   <= st_nxt;
      lfsr <= lfsr_next(lfsr);

      if (st_nxt != ST_RUN)     miss_cnt <= '0;
      else if (hit_wrong)       miss_cnt <= MISS_W'(HOLD);
      else if (miss_cnt != '0)  miss_cnt <= miss_cnt - MISS_W'(1);

      if (hit_ok || hit_wrong)  lock_cnt <= LOCK_W'(LOCKOUT);
      else if (lock_cnt != '0)  lock_cnt <= lock_cnt - LOCK_W'(1);

      if (hit_ok) begin
        idx <= idx_new;
        if (score_r != 8'hFF) score_r <= score_r + 8'd1;
      end
    end
  end

  assign score = score_r;
  assign state = st;

endmodule
